// File: rtl/seq_serializer.sv
// seq_serializer: parallel-to-serial front end feeding the sequence-detector din.
// Latency: first frame bit is on sout in the cycle after the accepting edge; WIDTH (+1 parity) bits per frame.
// Backpressure: pready is high only when idle or on the last bit of a frame, so back-to-back words go out gap-free.
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous reset, active-low
//   pdata      WIDTH-bit parallel word, captured when pvalid && pready
//   pvalid     upstream holds a word on pdata
//   pready     combinational; high in IDLE and on the final frame bit, 0 while rst is low
//   sout       registered serial data, IDLE_LVL between frames
//   sout_valid sout carries a frame bit (same as busy)
//   busy       a frame is being sent
//   done       1-cycle pulse on the final bit of a frame
//
// Optional feature: define SER_PARITY_EN to append a parity bit (^data ^ PARITY_ODD)
// after the data bits; done then pulses on the parity bit.

module seq_serializer #(
    parameter int WIDTH      = 8,
    parameter int MSB_FIRST  = 1,
    parameter int IDLE_LVL   = 0,
    parameter int PARITY_ODD = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] pdata,
    input  logic             pvalid,
    output logic             pready,
    output logic             sout,
    output logic             sout_valid,
    output logic             busy,
    output logic             done
);

    localparam int            CW       = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0] LAST     = CW'(WIDTH - 1);
    localparam logic          IDLE_BIT = IDLE_LVL[0];

    typedef enum logic [1:0] {
        S_IDLE,
        S_SHIFT
`ifdef SER_PARITY_EN
        ,S_PAR
`endif
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] shreg_q, shreg_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             sout_q, sout_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             accept;

`ifdef SER_PARITY_EN
    logic par_q, par_d;
`else
    logic unused_par;
    assign unused_par = PARITY_ODD[0];
`endif

    // The final bit of a frame (done_q) frees the block so the next word can
    // follow on the very next cycle.
    assign pready     = rst && (state_q == S_IDLE || done_q);
    assign accept     = pready && pvalid;
    assign sout       = sout_q;
    assign busy       = busy_q;
    assign sout_valid = busy_q;
    assign done       = done_q;

    always_comb begin
        state_d = state_q;
        shreg_d = shreg_q;
        cnt_d   = cnt_q;
        sout_d  = sout_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
`ifdef SER_PARITY_EN
        par_d   = par_q;
`endif
        if (accept) begin
            // First bit goes straight to the output flop; the shift register
            // holds only the bits still to be sent.
            state_d = S_SHIFT;
            cnt_d   = '0;
            busy_d  = 1'b1;
            if (MSB_FIRST != 0) begin
                sout_d  = pdata[WIDTH-1];
                shreg_d = {pdata[WIDTH-2:0], 1'b0};
            end else begin
                sout_d  = pdata[0];
                shreg_d = {1'b0, pdata[WIDTH-1:1]};
            end
`ifdef SER_PARITY_EN
            par_d = (^pdata) ^ PARITY_ODD[0];
`endif
        end else if (done_q || state_q == S_IDLE) begin
            state_d = S_IDLE;
            sout_d  = IDLE_BIT;
            busy_d  = 1'b0;
        end else if (state_q == S_SHIFT && cnt_q != LAST) begin
            // cnt_q is the index of the bit currently on sout.
            cnt_d = cnt_q + CW'(1);
            if (MSB_FIRST != 0) begin
                sout_d  = shreg_q[WIDTH-1];
                shreg_d = {shreg_q[WIDTH-2:0], 1'b0};
            end else begin
                sout_d  = shreg_q[0];
                shreg_d = {1'b0, shreg_q[WIDTH-1:1]};
            end
`ifndef SER_PARITY_EN
            done_d = (cnt_d == LAST);
`endif
        end
`ifdef SER_PARITY_EN
        else begin
            // Last data bit is on sout: parity bit closes the frame.
            state_d = S_PAR;
            sout_d  = par_q;
            done_d  = 1'b1;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= S_IDLE;
            shreg_q <= '0;
            cnt_q   <= '0;
            sout_q  <= IDLE_BIT;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
`ifdef SER_PARITY_EN
            par_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            shreg_q <= shreg_d;
            cnt_q   <= cnt_d;
            sout_q  <= sout_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
`ifdef SER_PARITY_EN
            par_q   <= par_d;
`endif
        end
    end

endmodule

// File: tb/tb_seq_serializer.sv
// tb_seq_serializer: checks an MSB-first and an LSB-first serializer against a frame-queue model.
// Latency: model emits the first frame bit in the cycle after acceptance.
// Backpressure: model accepts only when idle or on the last bit of the current frame.

module tb_seq_serializer;

`ifdef SER_PARITY_EN
    localparam int  FL  = 9;
    localparam bit  PAR = 1'b1;
`else
    localparam int  FL  = 8;
    localparam bit  PAR = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [7:0] pdata = 8'h00;
    logic       pvalid = 1'b0;

    logic m_pready, m_sout, m_sout_valid, m_busy, m_done;
    logic l_pready, l_sout, l_sout_valid, l_busy, l_done;

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    always #5 clk = ~clk;

    seq_serializer #(.WIDTH(8), .MSB_FIRST(1), .IDLE_LVL(0), .PARITY_ODD(0)) u_msb (
        .clk(clk), .rst(rst), .pdata(pdata), .pvalid(pvalid), .pready(m_pready),
        .sout(m_sout), .sout_valid(m_sout_valid), .busy(m_busy), .done(m_done)
    );

    seq_serializer #(.WIDTH(8), .MSB_FIRST(0), .IDLE_LVL(0), .PARITY_ODD(0)) u_lsb (
        .clk(clk), .rst(rst), .pdata(pdata), .pvalid(pvalid), .pready(l_pready),
        .sout(l_sout), .sout_valid(l_sout_valid), .busy(l_busy), .done(l_done)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- reference model: queue of pending frame bits ----------------
    typedef struct packed {
        logic bm;   // bit for MSB-first instance
        logic bl;   // bit for LSB-first instance
        logic dn;   // last bit of its frame
    } ent_t;

    ent_t q[$];
    logic cur_vld = 1'b0;
    logic cur_dn  = 1'b0;
    logic cur_bm  = 1'b0;
    logic cur_bl  = 1'b0;

    always @(posedge clk) begin
        ent_t e;
        if (!rst) begin
            q.delete();
            cur_vld = 1'b0;
            cur_dn  = 1'b0;
        end else begin
            if (pvalid && (!cur_vld || cur_dn)) begin
                for (int i = 0; i < 8; i++) begin
                    e.bm = pdata[7-i];
                    e.bl = pdata[i];
                    e.dn = (i == 7) && !PAR;
                    q.push_back(e);
                end
                if (PAR) begin
                    e.bm = ^pdata;
                    e.bl = ^pdata;
                    e.dn = 1'b1;
                    q.push_back(e);
                end
            end
            if (q.size() > 0) begin
                e = q.pop_front();
                cur_vld = 1'b1;
                cur_bm  = e.bm;
                cur_bl  = e.bl;
                cur_dn  = e.dn;
            end else begin
                cur_vld = 1'b0;
                cur_dn  = 1'b0;
            end
        end
    end

    // Per-cycle comparison of both instances against the model.
    always @(negedge clk) begin
        logic exp_rdy;
        if (chk_en) begin
            exp_rdy = rst && (!cur_vld || cur_dn);
            chk("m_pready", 32'(m_pready), 32'(exp_rdy));
            chk("l_pready", 32'(l_pready), 32'(exp_rdy));
            chk("m_sout", 32'(m_sout), 32'(cur_vld ? cur_bm : 1'b0));
            chk("l_sout", 32'(l_sout), 32'(cur_vld ? cur_bl : 1'b0));
            chk("m_sout_valid", 32'(m_sout_valid), 32'(cur_vld));
            chk("l_sout_valid", 32'(l_sout_valid), 32'(cur_vld));
            chk("m_busy", 32'(m_busy), 32'(cur_vld));
            chk("l_busy", 32'(l_busy), 32'(cur_vld));
            chk("m_done", 32'(m_done), 32'(cur_vld && cur_dn));
            chk("l_done", 32'(l_done), 32'(cur_vld && cur_dn));
        end
    end

    // ---------------- directed helpers ----------------
    function automatic logic [31:0] fr(input logic [7:0] x, input logic p);
        fr = PAR ? {23'd0, x, p} : {24'd0, x};
    endfunction

    task automatic collect(input int sel, input int n, output logic [31:0] b, output logic [31:0] d);
        b = '0;
        d = '0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            b = {b[30:0], (sel != 0) ? l_sout : m_sout};
            d = {d[30:0], (sel != 0) ? l_done : m_done};
        end
    endtask

    task automatic send(input logic [7:0] w);
        @(posedge clk); #1;
        pvalid = 1'b1;
        pdata  = w;
        @(posedge clk); #1;
        pvalid = 1'b0;
        pdata  = ~w;
    endtask

    logic [31:0] b1, d1, b2, d2;

    initial begin
        // Reset held with pvalid high: nothing may be accepted.
        rst    = 1'b0;
        pvalid = 1'b1;
        pdata  = 8'hAA;
        @(posedge clk); #1;
        chk_en = 1'b1;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            chk("rst_pready", 32'(m_pready), 32'd0);
            chk("rst_sout", 32'(m_sout), 32'd0);
            chk("rst_sout_valid", 32'(m_sout_valid), 32'd0);
            chk("rst_done", 32'(m_done), 32'd0);
            @(posedge clk); #1;
        end
        rst    = 1'b1;
        pvalid = 1'b0;

        // Single word, MSB first.
        send(8'hB4);
        collect(0, FL, b1, d1);
        chk("b4_bits", b1, fr(8'hB4, 1'b0));
        chk("b4_done", d1, 32'd1);
        @(negedge clk);
        chk("b4_idle_after", 32'(m_sout_valid), 32'd0);

        // Back-to-back words with pvalid held high.
        @(posedge clk); #1;
        pvalid = 1'b1;
        pdata  = 8'hD2;
        @(posedge clk); #1;
        pdata  = 8'h5A;
        collect(0, FL, b1, d1);
        @(posedge clk); #1;
        pvalid = 1'b0;
        collect(0, FL, b2, d2);
        chk("b2b_bits", (b1 << FL) | b2, (fr(8'hD2, 1'b0) << FL) | fr(8'h5A, 1'b0));
        chk("b2b_done", (d1 << FL) | d2, (32'd1 << FL) | 32'd1);

        // LSB first: 8'h0D -> 1,0,1,1,0,0,0,0
        send(8'h0D);
        collect(1, FL, b1, d1);
        chk("lsb_bits", b1, fr(8'hB0, 1'b1));
        chk("lsb_done", d1, 32'd1);

        // Reset during bit 3 of 8'hFF.
        send(8'hFF);
        repeat (4) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("midrst_sout", 32'(m_sout), 32'd0);
        chk("midrst_valid", 32'(m_sout_valid), 32'd0);
        chk("midrst_done", 32'(m_done), 32'd0);
        rst = 1'b1;
        send(8'h0F);
        collect(0, FL, b1, d1);
        chk("after_rst_bits", b1, fr(8'h0F, 1'b0));
        chk("after_rst_done", d1, 32'd1);

`ifdef SER_PARITY_EN
        send(8'h07);
        collect(0, FL, b1, d1);
        chk("par_07_bits", b1, fr(8'h07, 1'b1));
        chk("par_07_done", d1, 32'd1);
`endif

        // Randomized traffic with occasional resets.
        for (int c = 0; c < 3000; c++) begin
            @(posedge clk); #1;
            pvalid = ($urandom_range(0, 2) != 0);
            pdata  = 8'($urandom);
            rst    = ($urandom_range(0, 99) != 0);
        end
        @(posedge clk); #1;
        rst    = 1'b1;
        pvalid = 1'b0;
        repeat (20) @(posedge clk);
        #1;
        chk_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
